// File: rtl/pipe_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   state_e    : controller FSM state with fixed encodings (RUN=0, STALL_D=1, FLUSH=2)
//   StateW     : width of the exported state_o bus
//   cnt_width  : bits needed to hold a count in [0, max_val]
package pipe_hazard_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StRun    = 2'd0,
    StStallD = 2'd1,
    StFlush  = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// Shared IF/MEM memory-port arbiter with an IF starvation counter.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_ena           : advance enable; 0 holds the starvation counter
//   i_arb_en        : arbitrate (controller in RUN); otherwise MEM passes through
//   i_if_req        : IF requests the port
//   i_mem_req       : MEM requests the port
//   o_gnt_if        : port granted to IF
//   o_gnt_mem       : port granted to MEM
//   o_mem_stall     : MEM lost a conflict to a starved IF
//   o_if_blocked    : IF lost a conflict to MEM (front end must hold)
// Outputs are combinational; the controller registers them.
module mem_port_arb
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_mem_req,
  output logic o_gnt_if,
  output logic o_gnt_mem,
  output logic o_mem_stall,
  output logic o_if_blocked
);

  localparam int unsigned StarveW = cnt_width(STARVE_MAX);

  logic [StarveW-1:0] r_starve;
  logic [StarveW-1:0] w_starve_d;
  logic               w_conflict;
  logic               w_if_wins;

  always_comb begin
    w_conflict   = i_if_req & i_mem_req;
    w_if_wins    = w_conflict & (r_starve == StarveW'(STARVE_MAX));
    o_gnt_if     = 1'b0;
    o_gnt_mem    = 1'b0;
    o_mem_stall  = 1'b0;
    o_if_blocked = 1'b0;
    w_starve_d   = r_starve;
    if (i_arb_en) begin
      if (w_conflict) begin
        if (w_if_wins) begin
          // IF has been denied STARVE_MAX times in a row: let it through once.
          o_gnt_if    = 1'b1;
          o_mem_stall = 1'b1;
          w_starve_d  = '0;
        end else begin
          o_gnt_mem    = 1'b1;
          o_if_blocked = 1'b1;
          w_starve_d   = r_starve + StarveW'(1);
        end
      end else if (i_if_req) begin
        o_gnt_if   = 1'b1;
        w_starve_d = '0;
      end else if (i_mem_req) begin
        o_gnt_mem = 1'b1;
      end
    end else begin
      // Stall/flush: MEM keeps its port, IF is not fetching, counter frozen.
      o_gnt_mem = i_mem_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (i_ena) begin
      r_starve <= w_starve_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core. Turns hazard flags into registered
// stage enables, flushes and shared memory-port grants.
// Priority: mispredict flush > data stall > memory-port arbitration.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   ena                        : advance enable; 0 freezes all state and outputs
//   data_haz, fwd_ok           : RAW hazard in ID, and whether forwarding covers it
//   if_mem_req, mem_mem_req    : shared memory-port requests
//   br_issue, br_resolve       : branch issue / outcome-valid pulses
//   br_correct                 : prediction correct (qualified by br_resolve)
//   clr_cnt                    : synchronous clear of the event counters
//   pc_en, if_id_en, id_ex_en  : stage enables
//   flush_if_id, flush_id_ex   : stage flushes
//   gnt_if, gnt_mem, mem_stall : memory-port grants / MEM loss
//   state_o                    : FSM state (RUN=0, STALL_D=1, FLUSH=2)
//   br_pend, br_err            : branch outstanding / sticky double-issue error
//   flush_cnt, stall_cnt       : saturating mispredict-flush and data-stall counts
// Every output is registered: an event sampled at edge k is visible after edge k.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned LOAD_USE_CYC = 1,
  parameter int unsigned FLUSH_CYC    = 2,
  parameter int unsigned STARVE_MAX   = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              data_haz,
  input  logic              fwd_ok,
  input  logic              if_mem_req,
  input  logic              mem_mem_req,
  input  logic              br_issue,
  input  logic              br_resolve,
  input  logic              br_correct,
  input  logic              clr_cnt,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              gnt_if,
  output logic              gnt_mem,
  output logic              mem_stall,
  output logic [StateW-1:0] state_o,
  output logic              br_pend,
  output logic              br_err,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned TimerMax = (LOAD_USE_CYC > FLUSH_CYC) ? LOAD_USE_CYC : FLUSH_CYC;
  localparam int unsigned TimerW   = cnt_width(TimerMax - 1);

  // State and timer (timer = remaining cycles in STALL_D/FLUSH after the current one)
  state_e            r_state;
  state_e            w_state_d;
  logic [TimerW-1:0] r_timer;
  logic [TimerW-1:0] w_timer_d;

  // Registered outputs
  logic             r_pc_en, r_if_id_en, r_id_ex_en;
  logic             r_flush_if_id, r_flush_id_ex;
  logic             r_gnt_if, r_gnt_mem, r_mem_stall;
  logic             r_br_pend, r_br_err;
  logic [CNT_W-1:0] r_flush_cnt, r_stall_cnt;

  // Next-state wires
  logic             w_mispredict;
  logic             w_dstall;
  logic             w_flush_inc;
  logic             w_stall_inc;
  logic             w_arb_en;
  logic             w_gnt_if, w_gnt_mem, w_mem_stall, w_if_blocked;
  logic             w_pc_en_d, w_if_id_en_d, w_id_ex_en_d;
  logic             w_flush_if_id_d, w_flush_id_ex_d;
  logic             w_br_pend_d, w_br_err_d;
  logic [CNT_W-1:0] w_flush_cnt_d, w_stall_cnt_d;

  // A resolve only counts against a branch that is pending or issued this very cycle.
  assign w_mispredict = br_resolve & ~br_correct & (r_br_pend | br_issue);
  assign w_dstall     = data_haz & ~fwd_ok;

  always_comb begin
    w_state_d   = r_state;
    w_timer_d   = r_timer;
    w_flush_inc = 1'b0;
    w_stall_inc = 1'b0;
    if (w_mispredict) begin
      // Preempts a stall and restarts an ongoing flush.
      w_state_d   = StFlush;
      w_timer_d   = TimerW'(FLUSH_CYC - 1);
      w_flush_inc = 1'b1;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_dstall) begin
            w_state_d   = StStallD;
            w_timer_d   = TimerW'(LOAD_USE_CYC - 1);
            w_stall_inc = 1'b1;
          end
        end
        StStallD: begin
          if (r_timer != '0) begin
            w_timer_d = r_timer - TimerW'(1);
          end else if (w_dstall) begin
            // Hazard still present on the last stall cycle: stall again.
            w_timer_d   = TimerW'(LOAD_USE_CYC - 1);
            w_stall_inc = 1'b1;
          end else begin
            w_state_d = StRun;
          end
        end
        StFlush: begin
          if (r_timer != '0) begin
            w_timer_d = r_timer - TimerW'(1);
          end else begin
            w_state_d = StRun;
          end
        end
        default: begin
          w_state_d = StRun;
          w_timer_d = '0;
        end
      endcase
    end
  end

  // Grants are registered together with the state they belong to.
  assign w_arb_en = (w_state_d == StRun);

  mem_port_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_mem_port_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ena        (ena),
    .i_arb_en     (w_arb_en),
    .i_if_req     (if_mem_req),
    .i_mem_req    (mem_mem_req),
    .o_gnt_if     (w_gnt_if),
    .o_gnt_mem    (w_gnt_mem),
    .o_mem_stall  (w_mem_stall),
    .o_if_blocked (w_if_blocked)
  );

  always_comb begin
    w_pc_en_d       = 1'b1;
    w_if_id_en_d    = 1'b1;
    w_id_ex_en_d    = 1'b1;
    w_flush_if_id_d = 1'b0;
    w_flush_id_ex_d = 1'b0;
    unique case (w_state_d)
      StRun: begin
        // Front end holds while MEM owns the port against an IF request.
        w_pc_en_d    = ~w_if_blocked;
        w_if_id_en_d = ~w_if_blocked;
      end
      StStallD: begin
        w_pc_en_d       = 1'b0;
        w_if_id_en_d    = 1'b0;
        w_flush_id_ex_d = 1'b1;
      end
      StFlush: begin
        w_flush_if_id_d = 1'b1;
        w_flush_id_ex_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_br_err_d  = r_br_err | (br_issue & r_br_pend & ~br_resolve);
    if (br_resolve) begin
      w_br_pend_d = 1'b0;
    end else if (br_issue) begin
      w_br_pend_d = 1'b1;
    end else begin
      w_br_pend_d = r_br_pend;
    end
  end

  always_comb begin
    w_flush_cnt_d = r_flush_cnt;
    w_stall_cnt_d = r_stall_cnt;
    if (clr_cnt) begin
      w_flush_cnt_d = '0;
      w_stall_cnt_d = '0;
    end else begin
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        w_flush_cnt_d = r_flush_cnt + CNT_W'(1);
      end
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        w_stall_cnt_d = r_stall_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StRun;
      r_timer       <= '0;
      r_pc_en       <= 1'b1;
      r_if_id_en    <= 1'b1;
      r_id_ex_en    <= 1'b1;
      r_flush_if_id <= 1'b0;
      r_flush_id_ex <= 1'b0;
      r_gnt_if      <= 1'b0;
      r_gnt_mem     <= 1'b0;
      r_mem_stall   <= 1'b0;
      r_br_pend     <= 1'b0;
      r_br_err      <= 1'b0;
      r_flush_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else if (ena) begin
      r_state       <= w_state_d;
      r_timer       <= w_timer_d;
      r_pc_en       <= w_pc_en_d;
      r_if_id_en    <= w_if_id_en_d;
      r_id_ex_en    <= w_id_ex_en_d;
      r_flush_if_id <= w_flush_if_id_d;
      r_flush_id_ex <= w_flush_id_ex_d;
      r_gnt_if      <= w_gnt_if;
      r_gnt_mem     <= w_gnt_mem;
      r_mem_stall   <= w_mem_stall;
      r_br_pend     <= w_br_pend_d;
      r_br_err      <= w_br_err_d;
      r_flush_cnt   <= w_flush_cnt_d;
      r_stall_cnt   <= w_stall_cnt_d;
    end
  end

  assign pc_en       = r_pc_en;
  assign if_id_en    = r_if_id_en;
  assign id_ex_en    = r_id_ex_en;
  assign flush_if_id = r_flush_if_id;
  assign flush_id_ex = r_flush_id_ex;
  assign gnt_if      = r_gnt_if;
  assign gnt_mem     = r_gnt_mem;
  assign mem_stall   = r_mem_stall;
  assign state_o     = r_state;
  assign br_pend     = r_br_pend;
  assign br_err      = r_br_err;
  assign flush_cnt   = r_flush_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule
